// File: rtl/sprite_compositor.sv
// Three-stage sprite renderer: window test and ROM addressing, ROM read alignment,
// then priority merge with colour-key transparency and frog collision tracking.
module sprite_compositor #(
  parameter int unsigned TILE_SIZE      = 32,
  parameter int unsigned H_VISIBLE_AREA = 640,
  parameter int unsigned V_VISIBLE_AREA = 480,
  parameter int unsigned NUM_SPRITES    = 5,
  parameter logic [8:0]  TRANSPARENT    = 9'h1C7,
  parameter logic [8:0]  BG_COLOR       = 9'h000,
  parameter int unsigned ADDR_W         = $clog2(TILE_SIZE * TILE_SIZE)
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic [9:0]                    i_H_Counter,
  input  logic [9:0]                    i_V_Counter,
  input  logic [10*NUM_SPRITES-1:0]     i_Sprite_X,
  input  logic [10*NUM_SPRITES-1:0]     i_Sprite_Y,
  input  logic [NUM_SPRITES-1:0]        i_Sprite_En,
  input  logic [NUM_SPRITES-1:0]        i_Flip,
  output logic [ADDR_W*NUM_SPRITES-1:0] o_Rom_Addr,
  input  logic [9*NUM_SPRITES-1:0]      i_Rom_Data,
  output logic [2:0]                    o_Red,
  output logic [2:0]                    o_Grn,
  output logic [2:0]                    o_Blu,
  output logic                          o_Active,
  output logic [NUM_SPRITES-2:0]        o_Collision,
  output logic                          o_Frame_Done
);

  localparam int unsigned TW = $clog2(TILE_SIZE);
  localparam int unsigned CW = 9;

  logic                   vis_c;
  logic                   last_c;
  logic [NUM_SPRITES-1:0] hit_c;
  logic [NUM_SPRITES-1:0] opaque_c;
  logic [NUM_SPRITES-2:0] set_c;
  logic [CW-1:0]          color_c;
  logic                   frame_end_c;

  logic                   vis1, vis2;
  logic                   last1, last2, last3;
  logic [NUM_SPRITES-1:0] hit1, hit2;

  assign vis_c  = (i_H_Counter < 10'(H_VISIBLE_AREA)) && (i_V_Counter < 10'(V_VISIBLE_AREA));
  assign last_c = (i_H_Counter == 10'(H_VISIBLE_AREA - 1)) && (i_V_Counter == 10'(V_VISIBLE_AREA - 1));

  // Per-sprite window test (11-bit bounds so X+TILE_SIZE never wraps) and address register
  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_spr
    logic [10:0]     x_lo, y_lo, h_ext, v_ext;
    logic            in_x, in_y;
    logic [TW-1:0]   dx, dy, col;
    logic [ADDR_W-1:0] addr_q;

    assign x_lo  = {1'b0, i_Sprite_X[10*k +: 10]};
    assign y_lo  = {1'b0, i_Sprite_Y[10*k +: 10]};
    assign h_ext = {1'b0, i_H_Counter};
    assign v_ext = {1'b0, i_V_Counter};
    assign in_x  = (h_ext >= x_lo) && (h_ext < x_lo + 11'(TILE_SIZE));
    assign in_y  = (v_ext >= y_lo) && (v_ext < y_lo + 11'(TILE_SIZE));
    assign dx    = i_H_Counter[TW-1:0] - i_Sprite_X[10*k +: TW];
    assign dy    = i_V_Counter[TW-1:0] - i_Sprite_Y[10*k +: TW];
    assign col   = i_Flip[k] ? ~dx : dx;

    assign hit_c[k]    = i_Sprite_En[k] & vis_c & in_x & in_y;
    assign opaque_c[k] = hit2[k] & (i_Rom_Data[9*k +: 9] != TRANSPARENT);

    // Address holds while the sprite is not hit to avoid needless ROM toggling
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        addr_q <= '0;
      end else if (hit_c[k]) begin
        addr_q <= ADDR_W'({dy, col});
      end
    end

    assign o_Rom_Addr[ADDR_W*k +: ADDR_W] = addr_q;
  end

  // Lowest index opaque sprite wins; loop runs high to low so it is assigned last
  always_comb begin
    color_c = BG_COLOR;
    for (int k = int'(NUM_SPRITES) - 1; k >= 0; k--) begin
      if (opaque_c[k]) begin
        color_c = i_Rom_Data[9*k +: 9];
      end
    end
  end

  assign set_c       = {(NUM_SPRITES-1){opaque_c[0]}} & opaque_c[NUM_SPRITES-1:1];
  assign frame_end_c = last2 & ~last3;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vis1         <= 1'b0;
      vis2         <= 1'b0;
      last1        <= 1'b0;
      last2        <= 1'b0;
      last3        <= 1'b0;
      hit1         <= '0;
      hit2         <= '0;
      o_Red        <= '0;
      o_Grn        <= '0;
      o_Blu        <= '0;
      o_Active     <= 1'b0;
      o_Collision  <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      vis1         <= vis_c;
      last1        <= last_c;
      hit1         <= hit_c;
      vis2         <= vis1;
      last2        <= last1;
      hit2         <= hit1;
      last3        <= last2;
      o_Active     <= vis2;
      {o_Red, o_Grn, o_Blu} <= vis2 ? color_c : '0;
      o_Frame_Done <= frame_end_c;
      // Clear after the pulse, but keep any hit landing in that same cycle
      o_Collision  <= (o_Frame_Done ? '0 : o_Collision) | set_c;
    end
  end

endmodule
